arbiter_round_robin_held: RTL and testbench
===========================================

# arbiter_round_robin_held

Registered round-robin arbiter for WORD_WIDTH requesters. A granted requester keeps its grant for as long as it holds its request, or until an optional hold limit preempts it. Priority rotates past the most recent grantee, so no requester starves. It drives one-hot multiplexer selects and shared-resource ownership, and replaces plain priority arbitration wherever starvation or unbounded ownership is unacceptable.

## Interface
- WORD_WIDTH, 0 (must be set, ≥1): number of requesters; bit 0 is lowest index.
- HOLD_LIMIT, 0: maximum consecutive grant cycles before preemption; 0 disables preemption.
- IDX_WIDTH, derived: `max(1, clog2(WORD_WIDTH))`.
- CNT_WIDTH, derived: `max(1, clog2(HOLD_LIMIT+1))`.
- clock  input  1  single clock; all state updates on rising edge.
- clear_n  input  1  asynchronous, active-low reset.
- requests  input  WORD_WIDTH  request lines, held high for the whole transaction.
- grant  output  WORD_WIDTH  registered one-hot grant, or all-zero when idle.
- grant_valid  output  1  high when grant is non-zero.
- grant_index  output  IDX_WIDTH  binary index of the granted bit; holds its last value when idle.
- preempt  output  1  one-cycle pulse: the current grant was issued by preemption.

## Operation
- State: grant register, rotation pointer `ptr` (IDX_WIDTH), hold counter `cnt` (CNT_WIDTH).
- Two modes: IDLE (grant==0) and OWNED (grant one-hot).
- Selection function `pick(req)`:
  - If `req & {bits ≥ ptr}` is non-zero, take its lowest set bit.
  - Otherwise take the lowest set bit of `req`.
  - All-zero `req` returns zero.
- IDLE:
  - Each edge, grant <= pick(requests) and cnt <= 0.
  - On a non-zero pick, ptr <= (picked index + 1) mod WORD_WIDTH, grant_index <= picked index, and the mode goes to OWNED.
- OWNED, current index g, request still high, and either HOLD_LIMIT==0 or cnt < HOLD_LIMIT-1:
  - Keep the grant; cnt <= cnt+1 (stops counting when HOLD_LIMIT==0).
- OWNED, request g dropped (sampled low):
  - grant <= pick(requests). Handover needs no idle cycle.
  - The ptr, cnt, and mode rules are as in IDLE.
- OWNED, request g high and cnt == HOLD_LIMIT-1 (limit reached):
  - Let others = requests with bit g cleared.
  - If others is non-zero: grant <= pick(others), ptr updated, cnt <= 0, and preempt <= 1 for the next cycle.
  - If others is zero: g keeps the grant and cnt <= 0, with no preempt.
- The requester that loses a grant sees it drop on the same edge the new grantee sees its grant rise. grant is never two-hot.
- WORD_WIDTH==1: the grant follows the request with one cycle of latency and preempt never fires.
- Requests arriving while another requester holds the grant are ignored until release or preemption.

## Timing
- Reset (clear_n low, asynchronous) sets grant=0, grant_valid=0, grant_index=0, preempt=0, ptr=0, cnt=0.
- Reset deasserted mid-transaction restarts arbitration from ptr=0. The prior owner is not restored.
- Request-to-grant latency is 1 cycle. The first grant appears on the edge after a request is sampled while IDLE.
- Release-to-next-grant latency is 1 cycle. The drop is sampled at edge N; the new grant is visible after edge N.
- With HOLD_LIMIT=H>0, a contended owner holds the grant for exactly H cycles.
- preempt is high only during the first cycle of a preempting grant.
- Outputs are registered; there is no combinational path from requests to grant.

## Test plan
- **Reset:** assert clear_n=0 mid-grant with requests=4'b1111 -> immediately grant=0, valid=0, index=0, preempt=0. After release, the first grant is 4'b0001.
- **Basic rotation (WORD_WIDTH=4, HOLD_LIMIT=0):** requests=4'b1010, each grantee drops its request 2 cycles after its grant, then re-raises.
  - The grant sequence is 0010, 1000, 0010, 1000.
  - Each grant appears 1 cycle after the previous one drops, with no gap.
- **Hold without limit:** requests=4'b0011, bit0 held for 20 cycles -> grant stays 0001 for all 20 cycles. After bit0 drops, grant=0010 on the next cycle.
- **Preemption (HOLD_LIMIT=3):** requests=4'b0101 held permanently.
  - Grants alternate 0001 ×3 cycles, 0100 ×3 cycles, and so on.
  - preempt pulses on the first cycle of each grant after the first.
- **Limit, sole requester (HOLD_LIMIT=3):** requests=4'b0100 only -> grant stays 0100 continuously, preempt stays 0, and cnt wraps every 3 cycles.
- **Wrap-around:** with ptr=3 after granting bit 2, raise requests=4'b1001 -> grant=1000. Then drop bit 3 -> grant=0001, and ptr returns to 1.

Source files
------------

// File: rtl/arbiter_round_robin_held.sv
// Round-robin arbiter with grant hold: an owner keeps its grant while it
// requests, optionally preempted after HOLD_LIMIT consecutive cycles when
// another requester is waiting. All outputs come straight from flops.
module arbiter_round_robin_held #(
    parameter int unsigned WORD_WIDTH = 4,
    parameter int unsigned HOLD_LIMIT = 0,
    localparam int unsigned IDX_WIDTH = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1,
    localparam int unsigned CNT_WIDTH = ($clog2(HOLD_LIMIT + 1) > 1) ? $clog2(HOLD_LIMIT + 1) : 1
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [WORD_WIDTH-1:0] requests,
    output logic [WORD_WIDTH-1:0] grant,
    output logic                  grant_valid,
    output logic [IDX_WIDTH-1:0]  grant_index,
    output logic                  preempt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    localparam int unsigned         LIMIT_M1 = (HOLD_LIMIT > 0) ? HOLD_LIMIT - 1 : 0;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(WORD_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_TOP  = CNT_WIDTH'(LIMIT_M1);

    logic [0:0]            state_q, state_d;
    logic [WORD_WIDTH-1:0] grant_q, grant_d;
    logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  preempt_q, preempt_d;

    logic [WORD_WIDTH-1:0] sel_c;
    logic [WORD_WIDTH-1:0] others_c;
    logic                  owner_req_c;
    logic                  take_c;

    // Lowest set bit of v as a one-hot vector (zero in, zero out).
    function automatic logic [WORD_WIDTH-1:0] lowest(input logic [WORD_WIDTH-1:0] v);
        logic [WORD_WIDTH-1:0] r;
        logic                  found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Rotating priority: first request at or above p, else wrap to the bottom.
    function automatic logic [WORD_WIDTH-1:0] pick(input logic [WORD_WIDTH-1:0] req,
                                                   input logic [IDX_WIDTH-1:0]  p);
        logic [WORD_WIDTH-1:0] upper;
        upper = '0;
        for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
            upper[i] = req[i] && (IDX_WIDTH'(i) >= p);
        end
        return (|upper) ? lowest(upper) : lowest(req);
    endfunction

    // Binary index of a one-hot vector.
    function automatic logic [IDX_WIDTH-1:0] to_index(input logic [WORD_WIDTH-1:0] oh);
        logic [IDX_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
            if (oh[i]) r = r | IDX_WIDTH'(i);
        end
        return r;
    endfunction

    // Pointer moves one past the grantee, wrapping at the top requester.
    function automatic logic [IDX_WIDTH-1:0] next_ptr(input logic [IDX_WIDTH-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_WIDTH'(1);
    endfunction

    // Next-state logic: arbitrate when idle/released, count or preempt when owned.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        preempt_d   = 1'b0;
        sel_c       = '0;
        take_c      = 1'b0;
        owner_req_c = |(requests & grant_q);
        others_c    = requests & ~grant_q;

        if (state_q == ST_IDLE || !owner_req_c) begin
            sel_c  = pick(requests, ptr_q);
            take_c = 1'b1;
            cnt_d  = '0;
        end else if (HOLD_LIMIT == 0) begin
            cnt_d = cnt_q;
        end else if (cnt_q < CNT_TOP) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            cnt_d = '0;
            if (|others_c) begin
                sel_c     = pick(others_c, ptr_q);
                take_c    = 1'b1;
                preempt_d = 1'b1;
            end
        end

        if (take_c) begin
            grant_d = sel_c;
            if (|sel_c) begin
                idx_d   = to_index(sel_c);
                ptr_d   = next_ptr(idx_d);
                state_d = ST_OWNED;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = (state_q == ST_OWNED);
    assign grant_index = idx_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_arbiter_round_robin_held.sv
// Bench for arbiter_round_robin_held: one instance without hold limit (a),
// one with HOLD_LIMIT=3 (b). A behavioural model predicts each cycle's
// outputs into a scoreboard queue; directed checks cover the key scenarios.
module tb_arbiter_round_robin_held;

    localparam int unsigned W  = 4;
    localparam int unsigned IW = 2;

    logic          clock = 1'b0;
    logic          clear_n;
    logic [W-1:0]  ra, rb;
    logic [W-1:0]  grant_a, grant_b;
    logic          valid_a, valid_b;
    logic [IW-1:0] idx_a, idx_b;
    logic          pre_a, pre_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] ea;
        logic [7:0] eb;
    } exp_t;
    exp_t sbq[$];

    // Model state per instance: owner (-1 idle), pointer, counter, index, preempt.
    int m_own[2];
    int m_ptr[2];
    int m_cnt[2];
    int m_idx[2];
    bit m_pre[2];
    int lim[2] = '{0, 3};

    arbiter_round_robin_held #(.WORD_WIDTH(W), .HOLD_LIMIT(0)) u_a (
        .clock(clock), .clear_n(clear_n), .requests(ra),
        .grant(grant_a), .grant_valid(valid_a), .grant_index(idx_a), .preempt(pre_a)
    );

    arbiter_round_robin_held #(.WORD_WIDTH(W), .HOLD_LIMIT(3)) u_b (
        .clock(clock), .clear_n(clear_n), .requests(rb),
        .grant(grant_b), .grant_valid(valid_b), .grant_index(idx_b), .preempt(pre_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_idx(input logic [W-1:0] req, input int p);
        for (int s = 0; s < W; s++) begin
            int i;
            i = (p + s) % W;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1; m_ptr[k] = 0; m_cnt[k] = 0; m_idx[k] = 0; m_pre[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic [W-1:0] req);
        int p;
        m_pre[k] = 1'b0;
        if (m_own[k] < 0 || !req[m_own[k]]) begin
            p = pick_idx(req, m_ptr[k]);
            m_cnt[k] = 0;
            m_own[k] = p;
            if (p >= 0) begin
                m_ptr[k] = (p + 1) % W;
                m_idx[k] = p;
            end
        end else if (lim[k] == 0) begin
            m_cnt[k] = m_cnt[k];
        end else if (m_cnt[k] < lim[k] - 1) begin
            m_cnt[k]++;
        end else begin
            logic [W-1:0] others;
            others = req;
            others[m_own[k]] = 1'b0;
            m_cnt[k] = 0;
            p = pick_idx(others, m_ptr[k]);
            if (p >= 0) begin
                m_own[k] = p;
                m_ptr[k] = (p + 1) % W;
                m_idx[k] = p;
                m_pre[k] = 1'b1;
            end
        end
    endtask

    function automatic logic [7:0] model_out(input int k);
        logic [7:0] r;
        r[7:4] = (m_own[k] < 0) ? 4'b0000 : 4'(1 << m_own[k]);
        r[3]   = (m_own[k] >= 0);
        r[2:1] = 2'(m_idx[k]);
        r[0]   = m_pre[k];
        return r;
    endfunction

    // Drive current requests for one edge, push prediction, then compare.
    task automatic cycle();
        exp_t e;
        model_step(0, ra);
        model_step(1, rb);
        sbq.push_back('{ea: model_out(0), eb: model_out(1)});
        @(posedge clock);
        #1;
        e = sbq.pop_front();
        check("sb_a", {grant_a, valid_a, idx_a, pre_a}, e.ea);
        check("sb_b", {grant_b, valid_b, idx_b, pre_b}, e.eb);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_grant_a"}, grant_a, 4'b0000);
        check({tag, "_valid_a"}, valid_a, 1'b0);
        check({tag, "_idx_a"},   idx_a,   2'd0);
        check({tag, "_pre_a"},   pre_a,   1'b0);
        check({tag, "_grant_b"}, grant_b, 4'b0000);
        check({tag, "_valid_b"}, valid_b, 1'b0);
    endtask

    // Asynchronous reset between edges; released before the next edge.
    task automatic do_reset();
        clear_n = 1'b0;
        #1;
        reset_checks("async_rst");
        model_reset();
        clear_n = 1'b1;
    endtask

    initial begin
        clear_n = 1'b0;
        ra = '0;
        rb = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_checks("por");
        clear_n = 1'b1;

        // Reset in the middle of a grant, then restart from ptr=0.
        ra = 4'b1111; rb = 4'b1111;
        repeat (3) cycle();
        do_reset();
        cycle();
        check("rst_first_a", grant_a, 4'b0001);
        check("rst_first_b", grant_b, 4'b0001);
        ra = '0; rb = '0;
        cycle();

        // Basic rotation on a: 0010, 1000, 0010, 1000 with no idle gap.
        begin
            logic [W-1:0] rot_exp[3] = '{4'b1000, 4'b0010, 4'b1000};
            ra = 4'b1010;
            cycle();
            check("rot_0", grant_a, 4'b0010);
            for (int i = 0; i < 3; i++) begin
                ra = 4'b1010;
                cycle();
                ra = 4'b1010 & ~grant_a;
                cycle();
                check("rot_n", grant_a, rot_exp[i]);
                check("rot_valid", valid_a, 1'b1);
            end
        end
        ra = '0;
        cycle();

        // Hold without limit: bit0 keeps the grant for 20 cycles.
        ra = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("hold_nolim", grant_a, 4'b0001);
        end
        ra = 4'b0010;
        cycle();
        check("hold_release", grant_a, 4'b0010);
        check("hold_release_idx", idx_a, 2'd1);
        ra = '0;
        cycle();
        check("idle_idx_kept", idx_a, 2'd1);

        // Preemption on b: 0001 x3, 0100 x3, ... with a pulse on each handover.
        do_reset();
        rb = 4'b0101;
        for (int c = 0; c < 12; c++) begin
            cycle();
            check("preempt_grant", grant_b, ((c / 3) % 2 == 0) ? 4'b0001 : 4'b0100);
            check("preempt_pulse", pre_b, (c % 3 == 0 && c > 0) ? 1'b1 : 1'b0);
        end

        // Sole requester under a limit keeps the grant, never preempted.
        rb = 4'b0100;
        for (int c = 0; c < 9; c++) begin
            cycle();
            check("sole_grant", grant_b, 4'b0100);
            check("sole_pre", pre_b, 1'b0);
        end
        rb = '0;
        cycle();

        // Wrap-around on a: ptr=3 after bit 2, then 1000, then 0001 -> ptr=1.
        ra = 4'b0100;
        cycle();
        check("wrap_pre_grant", grant_a, 4'b0100);
        ra = '0;
        cycle();
        ra = 4'b1001;
        cycle();
        check("wrap_high", grant_a, 4'b1000);
        ra = 4'b0001;
        cycle();
        check("wrap_low", grant_a, 4'b0001);
        ra = '0;
        cycle();
        ra = 4'b0011;
        cycle();
        check("wrap_ptr1", grant_a, 4'b0010);
        ra = '0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
